// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory loads/stores over req/gnt/rvalid,
// stalls upstream while an access is in flight and emits a registered writeback packet.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rd_res_i,
    input  logic [4:0]        rd_i,
    input  logic              rd_we_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t            state_r, state_next_s;
    logic [3:0]        op_r;
    logic [1:0]        off_r;
    logic [ADDR_W-1:0] addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [3:0]        be_r;
    logic              we_r;
    logic [4:0]        rd_r;
    logic              rd_we_r;

    logic              is_load_s, is_store_s, misalign_s;
    logic [3:0]        be_s;
    logic [XLEN-1:0]   lane_s;

    // Align the returned word to the accessed lane and sign/zero extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [3:0] op,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   load_extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            OP_LBU:  load_extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            OP_LH:   load_extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            OP_LHU:  load_extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: load_extract = rdata;
        endcase
    endfunction

    // Decode the incoming op: class, alignment fault, byte lanes and replicated store data.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        be_s       = 4'b1111;
        lane_s     = wdata_i;
        case (mem_op_i)
            OP_LB, OP_LBU: is_load_s = 1'b1;
            OP_LH, OP_LHU: begin
                is_load_s  = 1'b1;
                misalign_s = addr_i[0];
            end
            OP_LW: begin
                is_load_s  = 1'b1;
                misalign_s = (addr_i[1:0] != 2'b00);
            end
            OP_SB: begin
                is_store_s = 1'b1;
                be_s       = 4'b0001 << addr_i[1:0];
                lane_s     = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                is_store_s = 1'b1;
                misalign_s = addr_i[0];
                be_s       = 4'b0011 << addr_i[1:0];
                lane_s     = {2{wdata_i[15:0]}};
            end
            OP_SW: begin
                is_store_s = 1'b1;
                misalign_s = (addr_i[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_i && (is_load_s || is_store_s) && !misalign_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_next_s = we_r ? IDLE : RESP;
                end else begin
                    state_next_s = REQ;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Capture registers, writeback packet and misalign report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r            <= 4'd0;
            off_r           <= 2'd0;
            addr_r          <= '0;
            wdata_r         <= '0;
            be_r            <= 4'd0;
            we_r            <= 1'b0;
            rd_r            <= 5'd0;
            rd_we_r         <= 1'b0;
            wb_valid_o      <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_rd_o         <= 5'd0;
            wb_data_o       <= '0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        if (!(is_load_s || is_store_s)) begin
                            wb_valid_o <= 1'b1;
                            wb_we_o    <= rd_we_i && (rd_i != 5'd0);
                            wb_rd_o    <= rd_i;
                            wb_data_o  <= rd_res_i;
                        end else if (misalign_s) begin
                            wb_valid_o      <= 1'b1;
                            wb_we_o         <= 1'b0;
                            wb_rd_o         <= rd_i;
                            misalign_o      <= 1'b1;
                            misalign_addr_o <= addr_i;
                        end else begin
                            op_r    <= mem_op_i;
                            off_r   <= addr_i[1:0];
                            addr_r  <= {addr_i[ADDR_W-1:2], 2'b00};
                            wdata_r <= lane_s;
                            be_r    <= be_s;
                            we_r    <= is_store_s;
                            rd_r    <= rd_i;
                            rd_we_r <= rd_we_i;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i && we_r) begin
                        wb_valid_o <= 1'b1;
                        wb_we_o    <= 1'b0;
                        wb_rd_o    <= rd_r;
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_we_o    <= rd_we_r && (rd_r != 5'd0);
                        wb_rd_o    <= rd_r;
                        wb_data_o  <= load_extract(op_r, off_r, dmem_rdata_i);
                    end
                end
                default: ;
            endcase
        end
    end

    // Request signals come straight from registered state and latched values.
    assign stall_o      = (state_r != IDLE);
    assign dmem_req_o   = (state_r == REQ);
    assign dmem_we_o    = we_r;
    assign dmem_be_o    = be_r;
    assign dmem_addr_o  = addr_r;
    assign dmem_wdata_o = wdata_r;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. It consumes the registered execute result (ALU result, memory op, address, store data, destination register) and performs data-memory loads and stores over a req/gnt/rvalid interface. It freezes upstream while an access is in flight. It produces a registered writeback packet for the register file, with load data aligned and sign- or zero-extended.

Parameters:
- ADDR_W, 32, data-memory byte-address width
- XLEN, 32, data width; the only supported value is 32

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- valid_i  in  1  execute output holds a valid instruction
- mem_op_i  in  4  0=NOP, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; 9-15 are treated as NOP
- addr_i  in  ADDR_W  effective byte address (ALU result)
- wdata_i  in  XLEN  store data (rs2)
- rd_res_i  in  XLEN  ALU/branch result for non-memory instructions
- rd_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- stall_o  out  1  upstream must hold all *_i inputs stable
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = store
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata_o  out  XLEN  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  XLEN  load data word
- wb_valid_o  out  1  writeback packet valid (one-cycle pulse per instruction)
- wb_we_o  out  1  register-file write enable
- wb_rd_o  out  5  writeback register
- wb_data_o  out  XLEN  writeback data
- misalign_o  out  1  one-cycle pulse: misaligned access was dropped
- misalign_addr_o  out  ADDR_W  faulting address; held until the next misalign event

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE
  - all outputs 0, including stall_o, dmem_req_o and wb_valid_o
  - capture registers cleared
- FSM states: IDLE, REQ, RESP.
- stall_o = (state != IDLE). It is derived only from registered state and never depends combinationally on the current-cycle inputs.
- IDLE with valid_i:
  - Non-memory op (NOP): the next cycle gives wb_valid=1, wb_we=rd_we_i&(rd_i!=0), wb_rd=rd_i, wb_data=rd_res_i. Latency is 1 cycle and throughput is 1 instruction/cycle.
  - Misaligned memory op: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. No request is issued. The next cycle gives misalign_o=1, misalign_addr_o=addr_i, wb_valid=1, wb_we=0. State stays IDLE.
  - Aligned memory op: latch op, addr, wdata, rd and rd_we, then go to REQ.
- IDLE with valid_i=0: wb_valid=0 next cycle.
- REQ:
  - Drive dmem_req_o=1, together with dmem_we_o/be/addr/wdata taken from the latched values. These signals are held constant until gnt.
  - Store and gnt: go to IDLE. The next cycle gives wb_valid=1, wb_we=0.
  - Load and gnt: go to RESP.
  - dmem_rvalid_i is ignored in REQ.
- RESP:
  - dmem_req_o=0.
  - On rvalid: go to IDLE. The next cycle gives wb_valid=1, wb_we=latched rd_we&(rd!=0), wb_data=extracted load data.
  - rvalid arriving the same cycle as gnt is illegal for the memory and is not supported.
- Store byte lanes (off = addr[1:0]):
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}
  - SH: be=4'b0011<<off (off is 0 or 2), wdata={2{wdata[15:0]}}
  - SW: be=4'b1111, wdata=wdata
- Load extraction: sh = rdata>>(8*off).
  - LB: sign-extend sh[7:0]; LBU: zero-extend sh[7:0]
  - LH: sign-extend sh[15:0]; LHU: zero-extend sh[15:0]
  - LW: rdata
- Loads: dmem_we_o=0 and be=4'b1111.
- Minimum latency: store 2 cycles (gnt in the first REQ cycle); load 3 cycles (gnt in the first REQ cycle, rvalid in the first RESP cycle).
- Inputs are sampled only in IDLE. While stall_o=1, input changes have no effect.
- Reset mid-access: returns to IDLE immediately and drops dmem_req_o. The memory side must discard the outstanding response. No wb pulse is produced for the aborted instruction.
- wb_* outputs are registered and updated every cycle. When no instruction completes, wb_valid=0 and the other wb_* fields hold their previous values.

Test Plan:
- Non-memory: valid_i=1, mem_op=NOP, rd_res=0x1234, rd=5, rd_we=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, stall_o=0.
- SB: addr=0x103, wdata=0xAABBCCDD, gnt delayed 3 cycles -> req/be=4'b1000/addr=0x100/wdata=0xDDDDDDDD held steady; stall_o=1 for 4 cycles; then wb_valid=1, wb_we=0.
- LB: addr=0x102, rdata=0x0080FF00 (byte=0x80), rvalid 2 cycles after gnt -> wb_data=0xFFFFFF80; LBU with the same stimulus -> wb_data=0x00000080.
- LH: addr=0x102, rdata=0x8001_0000 -> wb_data=0xFFFF8001; LW with rd=0 -> wb_we=0.
- Misaligned LW: addr=0x101 -> no dmem_req_o; misalign_o=1, misalign_addr_o=0x101, wb_valid=1, wb_we=0; stall_o stays 0.
- Reset asserted during RESP -> dmem_req_o=0, stall_o=0, no wb pulse; a later rvalid while in IDLE is ignored.
